mux_n_rr: RTL



---
 rtl/mux_n_rr.sv | 96 +++++++++
 1 files changed

// File: rtl/mux_n_rr.sv
// N-input registered selector with valid/ready output, per-channel grants,
// direct-select and round-robin arbitration, and an out-of-range-select flag.
module mux_n_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 3,
  parameter int SW    = 3
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [N*WIDTH-1:0] Hyrja,
  input  logic [N-1:0]       Valid,
  output logic [N-1:0]       Grant,
  input  logic [SW-1:0]      S,
  input  logic               Mode,
  output logic [WIDTH-1:0]   Dalja,
  output logic               DaljaValid,
  input  logic               DaljaReady,
  output logic               Gabim,
  output logic [SW-1:0]      Ptr
);

  logic [WIDTH-1:0] dalja_q, dalja_d;
  logic             vld_q, vld_d;
  logic             gabim_q, gabim_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic load;
  logic s_ok;
  logic cand;
  logic gnt_any;
  int   s_idx;
  int   gnt_idx;
  int   rr_idx;

  always_comb begin
    load    = !vld_q || DaljaReady;
    s_idx   = int'(S);
    s_ok    = (s_idx < N);
    cand    = 1'b0;
    gnt_idx = 0;
    rr_idx  = 0;

    if (!Mode) begin
      if (s_ok && Valid[s_idx]) begin
        cand    = 1'b1;
        gnt_idx = s_idx;
      end
    end else begin
      // First requester at or after the pointer, wrapping modulo N.
      for (int k = 0; k < N; k++) begin
        rr_idx = (int'(ptr_q) + k) % N;
        if (!cand && Valid[rr_idx]) begin
          cand    = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end

    gnt_any = cand && load;
    Grant   = '0;
    if (gnt_any) Grant[gnt_idx] = 1'b1;

    dalja_d = dalja_q;
    vld_d   = vld_q;
    ptr_d   = ptr_q;
    if (gnt_any) begin
      dalja_d = Hyrja[gnt_idx*WIDTH +: WIDTH];
      vld_d   = 1'b1;
      if (Mode) ptr_d = SW'((gnt_idx + 1) % N);
    end else if (DaljaReady) begin
      vld_d = 1'b0;
    end

    gabim_d = !Mode && !s_ok;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      dalja_q <= '0;
      vld_q   <= 1'b0;
      gabim_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      dalja_q <= dalja_d;
      vld_q   <= vld_d;
      gabim_q <= gabim_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Dalja      = dalja_q;
  assign DaljaValid = vld_q;
  assign Gabim      = gabim_q;
  assign Ptr        = ptr_q;

endmodule
